alu_stage: RTL and testbench
============================

// Module: alu_stage
// PURPOSE
//  Registered 6502 ALU stage that sits directly downstream of the 8-bit register cells.
//  - Consumes register data_out values as operands A and B.
//  - Computes the result and NZCV flags; decimal mode takes an extra BCD-adjust cycle.
//  - Drives result_out back to the destination register's data_in, plus a clean wr_latch pulse.
// PARAMETERS
//  WIDTH     8   datapath width; BCD adjust is defined only for 8
// PORTS
//  clk          in   1      system clock; all state updates on posedge
//  rst_n        in   1      reset, asynchronous, active-low
//  start        in   1      1-cycle request; sampled only in IDLE
//  op           in   4      opcode (see alu_defs.vh), sampled with start
//  a_in         in   WIDTH  operand A (accumulator/register data_out)
//  b_in         in   WIDTH  operand B (memory/index register data_out)
//  c_in         in   1      carry flag in
//  d_in         in   1      decimal flag in; affects ADC/SBC only
//  busy         out  1      high in every state except IDLE
//  result_out   out  WIDTH  registered result; feeds register data_in
//  wr_latch     out  1      1-cycle pulse; feeds register latch
//  flags_out    out  4      {N,V,Z,C}, registered
//  flags_valid  out  1      1-cycle pulse; flags_out is updated
// BEHAVIOUR
//  Reset: state=IDLE; result_out=8'h00, flags_out=4'h0; busy, wr_latch and flags_valid all 0.
//  Reset mid-operation aborts the operation; wr_latch does not pulse.
//  Opcodes: ADC SBC AND ORA EOR ASL LSR ROL ROR INC DEC CMP PASSB; all others act as PASSB.
//  FSM: IDLE -> EXEC -> (ADJ if d_in and op is ADC/SBC) -> DONE -> WR -> IDLE.
//  Edge k samples start; op/a/b/c/d are captured into internal operand regs at that edge.
//  start while busy is ignored; the captured operands are not disturbed.
//  EXEC: binary result plus flags computed into result_out and flags_out.
//   ADC: {C,r}=A+B+c. SBC: {C,r}=A+~B+c. V=(A[7]~^Bx[7])&(A[7]^r[7]), Bx=B or ~B.
//   AND/ORA/EOR: C=c_in, V=0. ASL/ROL: C=A[7]; LSR/ROR: C=A[0]; ROL/ROR shift c_in in.
//   INC/DEC on A, wrap 8'hFF<->8'h00; C=c_in. CMP: C=(A>=B), result not written.
//   PASSB: r=B; C=c_in. V=0 for every op except ADC/SBC.
//  ADJ (decimal ADC/SBC only), NMOS semantics:
//   ADC adds 6 to any nibble >9 (low nibble first, carry into high); C = decimal carry.
//   SBC subtracts 6 from any nibble that borrowed; C = no-borrow.
//   N, V, Z keep their binary values from EXEC; only result_out and C change.
//  DONE: flags_valid=1 for this one cycle. result_out is stable from here.
//  WR: wr_latch=1 for exactly one cycle unless op=CMP. result_out was stable >=1 clk before the rise.
//  Latency from start edge k: binary op, wr_latch high in cycle k+3; decimal op, k+4.
//   A new start is accepted in IDLE at k+4 (binary) or k+5 (decimal).
//  result_out and flags_out hold their values until the next operation's EXEC.
// STRUCTURE
//  alu_defs.vh: opcode localparams, FSM state encodings, flag bit indices (N=3,V=2,Z=1,C=0).
//  Sub-module bcd_adjust: combinational nibble correction {bin_r, bin_c, half_c, is_sub} -> {r, c}.
//  Top holds the FSM, operand capture regs and the binary ALU.
// TESTING
//  1. ADC a=50 b=50 c=0 d=0 -> result 0xA0, NVZC=1100, wr_latch at k+3.
//  2. ADC decimal a=99 b=01 c=0 d=1 -> 0x00, C=1, wr_latch at k+4; also 09+01 -> 0x10, C=0.
//  3. SBC a=00 b=01 c=1 d=0 -> 0xFF, N=1 C=0; decimal 10-01 c=1 -> 0x09, C=1.
//  4. CMP a=40 b=40 -> Z=1 C=1, flags_valid pulses, no wr_latch.
//     ROR a=01 c=1 -> 0x80, C=1.
//  5. start pulsed again at k+1 -> ignored, first result intact.
//     INC 0xFF -> 0x00, Z=1.
//  6. rst_n low during ADJ -> all outputs 0 asynchronously, no wr_latch; next start runs normally.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// Shared definitions for the registered 6502 ALU stage: opcodes, FSM states, flag layout.
package alu_stage_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADC   = 4'h0;
    localparam logic [OP_W-1:0] OP_SBC   = 4'h1;
    localparam logic [OP_W-1:0] OP_AND   = 4'h2;
    localparam logic [OP_W-1:0] OP_ORA   = 4'h3;
    localparam logic [OP_W-1:0] OP_EOR   = 4'h4;
    localparam logic [OP_W-1:0] OP_ASL   = 4'h5;
    localparam logic [OP_W-1:0] OP_LSR   = 4'h6;
    localparam logic [OP_W-1:0] OP_ROL   = 4'h7;
    localparam logic [OP_W-1:0] OP_ROR   = 4'h8;
    localparam logic [OP_W-1:0] OP_INC   = 4'h9;
    localparam logic [OP_W-1:0] OP_DEC   = 4'hA;
    localparam logic [OP_W-1:0] OP_CMP   = 4'hB;
    localparam logic [OP_W-1:0] OP_PASSB = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_ADJ,
        ST_DONE,
        ST_WR
    } state_t;

    // Bit order matches flags_out = {N,V,Z,C}
    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } flags_t;

    // Only ADC/SBC honour the decimal flag
    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_stage_bcd_adjust.sv
// NMOS-style decimal correction of a binary ADC/SBC result, one nibble at a time.
module alu_stage_bcd_adjust
    import alu_stage_pkg::*;
(
    input  logic [7:0] i_bin_r,
    input  logic       i_bin_c,
    input  logic       i_half_c,
    input  logic       i_is_sub,
    output logic [7:0] o_r_c,
    output logic       o_carry_c
);

    logic       w_lo_big;
    logic       w_hi_big;
    logic [3:0] w_lo;
    logic [3:0] w_hi;
    logic [4:0] w_hi5;

    always_comb begin
        w_lo_big  = 1'b0;
        w_hi_big  = 1'b0;
        w_lo      = i_bin_r[3:0];
        w_hi      = i_bin_r[7:4];
        w_hi5     = {i_bin_c, i_bin_r[7:4]};
        o_carry_c = i_bin_c;
        if (i_is_sub) begin
            // A nibble borrowed when its carry-out is clear; carry stays the binary no-borrow
            if (!i_half_c) w_lo = i_bin_r[3:0] - 4'd6;
            if (!i_bin_c)  w_hi = i_bin_r[7:4] - 4'd6;
        end else begin
            // Low digit sum is {half_c, r_lo}; a correction there always carries into the high digit
            w_lo_big  = i_half_c || (i_bin_r[3:0] > 4'd9);
            w_lo      = i_bin_r[3:0] + (w_lo_big ? 4'd6 : 4'd0);
            w_hi5     = {i_bin_c, i_bin_r[7:4]} + {4'd0, w_lo_big & ~i_half_c};
            w_hi_big  = (w_hi5 > 5'd9);
            w_hi      = w_hi5[3:0] + (w_hi_big ? 4'd6 : 4'd0);
            o_carry_c = w_hi_big;
        end
        o_r_c = {w_hi, w_lo};
    end

endmodule

// File: rtl/alu_stage.sv
// Registered 6502 ALU stage: captures operands on start, computes result/NZCV,
// optionally BCD-adjusts, then pulses flags_valid and a write latch for the destination register.
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             d_in,
    output logic             busy,
    output logic [WIDTH-1:0] result_out,
    output logic             wr_latch,
    output logic [3:0]       flags_out,
    output logic             flags_valid
);

    localparam int unsigned MSB = WIDTH - 1;

    state_t           r_state,       w_state_nxt;
    logic [OP_W-1:0]  r_op,          w_op_nxt;
    logic [WIDTH-1:0] r_a,           w_a_nxt;
    logic [WIDTH-1:0] r_b,           w_b_nxt;
    logic             r_c,           w_c_nxt;
    logic             r_dec,         w_dec_nxt;
    logic             r_half_c,      w_half_c_nxt;
    logic             r_busy,        w_busy_nxt;
    logic [WIDTH-1:0] r_result,      w_result_nxt;
    flags_t           r_flags,       w_flags_nxt;
    logic             r_wr_latch,    w_wr_latch_nxt;
    logic             r_flags_valid, w_flags_valid_nxt;

    logic             w_is_sub;
    logic             w_cin;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_bin_r;
    logic             w_bin_c;
    logic             w_bin_v;
    logic             w_half_c;
    logic [7:0]       w_adj_r;
    logic             w_adj_c;

    // Binary ALU on the captured operands; CMP reuses the subtractor with a forced carry-in
    always_comb begin
        w_is_sub = (r_op == OP_SBC) || (r_op == OP_CMP);
        w_cin    = (r_op == OP_CMP) ? 1'b1 : r_c;
        w_bx     = w_is_sub ? ~r_b : r_b;
        w_sum    = {1'b0, r_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};
        w_half_c = r_a[4] ^ w_bx[4] ^ w_sum[4];
        w_bin_r  = r_b;
        w_bin_c  = r_c;
        w_bin_v  = 1'b0;
        case (r_op)
            OP_ADC, OP_SBC: begin
                w_bin_r = w_sum[WIDTH-1:0];
                w_bin_c = w_sum[WIDTH];
                w_bin_v = (r_a[MSB] ~^ w_bx[MSB]) & (r_a[MSB] ^ w_sum[MSB]);
            end
            OP_AND: w_bin_r = r_a & r_b;
            OP_ORA: w_bin_r = r_a | r_b;
            OP_EOR: w_bin_r = r_a ^ r_b;
            OP_ASL: {w_bin_c, w_bin_r} = {r_a, 1'b0};
            OP_LSR: {w_bin_r, w_bin_c} = {1'b0, r_a};
            OP_ROL: {w_bin_c, w_bin_r} = {r_a, r_c};
            OP_ROR: {w_bin_r, w_bin_c} = {r_c, r_a};
            OP_INC: w_bin_r = r_a + WIDTH'(1);
            OP_DEC: w_bin_r = r_a - WIDTH'(1);
            OP_CMP: begin
                w_bin_r = w_sum[WIDTH-1:0];
                w_bin_c = w_sum[WIDTH];
            end
            default: w_bin_r = r_b;
        endcase
    end

    alu_stage_bcd_adjust u_bcd_adjust (
        .i_bin_r   (8'(r_result)),
        .i_bin_c   (r_flags.c),
        .i_half_c  (r_half_c),
        .i_is_sub  (r_op == OP_SBC),
        .o_r_c     (w_adj_r),
        .o_carry_c (w_adj_c)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_c_nxt      = r_c;
        w_dec_nxt    = r_dec;
        w_half_c_nxt = r_half_c;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_nxt    = op;
                    w_a_nxt     = a_in;
                    w_b_nxt     = b_in;
                    w_c_nxt     = c_in;
                    w_dec_nxt   = d_in && is_arith(op);
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_op != OP_CMP) w_result_nxt = w_bin_r;
                w_flags_nxt.n = w_bin_r[MSB];
                w_flags_nxt.v = w_bin_v;
                w_flags_nxt.z = (w_bin_r == '0);
                w_flags_nxt.c = w_bin_c;
                w_half_c_nxt  = w_half_c;
                w_state_nxt   = r_dec ? ST_ADJ : ST_DONE;
            end
            ST_ADJ: begin
                w_result_nxt  = WIDTH'(w_adj_r);
                w_flags_nxt.c = w_adj_c;
                w_state_nxt   = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_WR;
            ST_WR:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt        = (w_state_nxt != ST_IDLE);
        w_flags_valid_nxt = (w_state_nxt == ST_DONE);
        w_wr_latch_nxt    = (w_state_nxt == ST_WR) && (r_op != OP_CMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= 1'b0;
            r_dec         <= 1'b0;
            r_half_c      <= 1'b0;
            r_busy        <= 1'b0;
            r_result      <= '0;
            r_flags       <= '0;
            r_wr_latch    <= 1'b0;
            r_flags_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_op          <= w_op_nxt;
            r_a           <= w_a_nxt;
            r_b           <= w_b_nxt;
            r_c           <= w_c_nxt;
            r_dec         <= w_dec_nxt;
            r_half_c      <= w_half_c_nxt;
            r_busy        <= w_busy_nxt;
            r_result      <= w_result_nxt;
            r_flags       <= w_flags_nxt;
            r_wr_latch    <= w_wr_latch_nxt;
            r_flags_valid <= w_flags_valid_nxt;
        end
    end

    assign busy        = r_busy;
    assign result_out  = r_result;
    assign flags_out   = r_flags;
    assign wr_latch    = r_wr_latch;
    assign flags_valid = r_flags_valid;

endmodule

// File: tb/tb_alu_stage.sv
// Bench for alu_stage: arithmetic reference model with a per-cycle timeline, directed pins, random traffic.
module tb_alu_stage;
    import alu_stage_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op    = 4'h0;
    logic [7:0] a_in  = 8'h00;
    logic [7:0] b_in  = 8'h00;
    logic       c_in  = 1'b0;
    logic       d_in  = 1'b0;
    logic       busy;
    logic [7:0] result_out;
    logic       wr_latch;
    logic [3:0] flags_out;
    logic       flags_valid;

    int total = 0;
    int bad   = 0;

    alu_stage #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .d_in        (d_in),
        .busy        (busy),
        .result_out  (result_out),
        .wr_latch    (wr_latch),
        .flags_out   (flags_out),
        .flags_valid (flags_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference ALU from the 6502 rules, integer arithmetic; returns {result, N, V, Z, C}
    function automatic logic [11:0] ref_alu(input logic [3:0] f_op, input logic [7:0] f_a,
                                            input logic [7:0] f_b, input logic f_c, input logic f_d);
        int ia, ib, ic, sa, sb, s, sv, lo, hi;
        logic [7:0] r;
        logic n, v, z, cy;
        ia = int'(f_a);
        ib = int'(f_b);
        ic = f_c ? 1 : 0;
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        r  = f_b;
        cy = f_c;
        v  = 1'b0;
        case (f_op)
            OP_ADC: begin
                s = ia + ib + ic; r = 8'(s); cy = (s > 255);
                sv = sa + sb + ic; v = (sv > 127) || (sv < -128);
            end
            OP_SBC: begin
                s = ia - ib - (1 - ic); r = 8'(s); cy = (s >= 0);
                sv = sa - sb - (1 - ic); v = (sv > 127) || (sv < -128);
            end
            OP_AND: r = f_a & f_b;
            OP_ORA: r = f_a | f_b;
            OP_EOR: r = f_a ^ f_b;
            OP_ASL: begin r = 8'(ia * 2);            cy = (ia > 127);    end
            OP_LSR: begin r = 8'(ia / 2);            cy = (ia % 2 == 1); end
            OP_ROL: begin r = 8'(ia * 2 + ic);       cy = (ia > 127);    end
            OP_ROR: begin r = 8'(ia / 2 + ic * 128); cy = (ia % 2 == 1); end
            OP_INC: r = 8'(ia + 1);
            OP_DEC: r = 8'(ia + 255);
            OP_CMP: begin r = 8'(ia - ib); cy = (ia >= ib); end
            default: r = f_b;
        endcase
        n = r[7];
        z = (r == 8'h00);
        if (f_d && f_op == OP_ADC) begin
            lo = ia % 16 + ib % 16 + ic;
            if (lo > 9) lo = lo + 6;
            hi = ia / 16 + ib / 16 + ((lo > 15) ? 1 : 0);
            if (hi > 9) hi = hi + 6;
            r  = 8'(hi * 16 + lo % 16);
            cy = (hi > 15);
        end
        if (f_d && f_op == OP_SBC) begin
            lo = ia % 16 - ib % 16 - (1 - ic);
            hi = ia / 16 - ib / 16;
            if (lo < 0) begin hi = hi - 1; lo = lo - 6; end
            if (hi < 0) hi = hi - 6;
            r  = 8'(hi * 16 + (lo & 15));
        end
        return {r, n, v, z, cy};
    endfunction

    // Timeline model: m_age counts edges since an accepted start; m_len edges until idle
    bit         m_act = 1'b0;
    int         m_age = 0;
    int         m_len = 3;
    bit         m_cmp = 1'b0;
    logic [7:0] m_r   = 8'h00;
    logic [3:0] m_f   = 4'h0;
    logic [11:0] m_pend = 12'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 1'b0; m_age = 0; m_len = 3; m_cmp = 1'b0;
            m_r = 8'h00; m_f = 4'h0; m_pend = 12'h0;
        end else if ((!m_act || m_age >= m_len) && start) begin
            m_act  = 1'b1;
            m_age  = 0;
            m_len  = (d_in && (op == OP_ADC || op == OP_SBC)) ? 4 : 3;
            m_cmp  = (op == OP_CMP);
            m_pend = ref_alu(op, a_in, b_in, c_in, d_in);
        end else if (m_act && m_age < m_len) begin
            m_age++;
            if (m_age == m_len - 2) begin
                m_f = m_pend[3:0];
                if (!m_cmp) m_r = m_pend[11:4];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy",        32'(busy),        32'(m_act && m_age < m_len));
            chk("flags_valid", 32'(flags_valid), 32'(m_act && m_age == m_len - 2));
            chk("wr_latch",    32'(wr_latch),    32'(m_act && m_age == m_len - 1 && !m_cmp));
            // The decimal-adjust cycle shows an intermediate binary value; skip it
            if (!(m_act && m_len == 4 && m_age == 1)) begin
                chk("result", 32'(result_out), 32'(m_r));
                chk("flags",  32'(flags_out),  32'(m_f));
            end
        end
    end

    task automatic run_op(input string nm, input logic [3:0] op_v, input logic [7:0] a_v,
                          input logic [7:0] b_v, input logic c_v, input logic d_v,
                          input logic [7:0] exp_r, input logic [3:0] exp_f, input bit repulse);
        int wr_at, n, exp_idle, exp_wr;
        exp_idle = (d_v && (op_v == OP_ADC || op_v == OP_SBC)) ? 4 : 3;
        exp_wr   = (op_v == OP_CMP) ? -1 : exp_idle - 1;
        @(negedge clk);
        start = 1'b1; op = op_v; a_in = a_v; b_in = b_v; c_in = c_v; d_in = d_v;
        @(posedge clk);
        @(negedge clk);
        if (repulse) begin
            start = 1'b1; op = OP_PASSB; a_in = 8'h11; b_in = 8'h77; c_in = 1'b1; d_in = 1'b0;
        end else begin
            start = 1'b0;
        end
        wr_at = -1;
        n = 0;
        while (busy && n < 10) begin
            if (wr_latch && wr_at < 0) wr_at = n;
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk({nm, "_wr_at"},   32'(wr_at), 32'(exp_wr));
        chk({nm, "_idle_at"}, 32'(n),     32'(exp_idle));
        chk({nm, "_result"},  32'(result_out), 32'(exp_r));
        chk({nm, "_flags"},   32'(flags_out),  32'(exp_f));
    endtask

    initial begin
        #3;
        chk("rst_busy",   32'(busy),        32'h0);
        chk("rst_result", 32'(result_out),  32'h0);
        chk("rst_flags",  32'(flags_out),   32'h0);
        chk("rst_wr",     32'(wr_latch),    32'h0);
        chk("rst_fv",     32'(flags_valid), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        run_op("adc_bin",   OP_ADC, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1100, 1'b0);
        run_op("adc_dec99", OP_ADC, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 4'b1001, 1'b0);
        run_op("adc_dec09", OP_ADC, 8'h09, 8'h01, 1'b0, 1'b1, 8'h10, 4'b0000, 1'b0);
        run_op("sbc_bin",   OP_SBC, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1000, 1'b0);
        run_op("sbc_dec",   OP_SBC, 8'h10, 8'h01, 1'b1, 1'b1, 8'h09, 4'b0001, 1'b0);
        run_op("cmp_eq",    OP_CMP, 8'h40, 8'h40, 1'b0, 1'b0, 8'h09, 4'b0011, 1'b0);
        run_op("ror",       OP_ROR, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1001, 1'b0);
        run_op("repulse",   OP_ADC, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 4'b0000, 1'b1);
        run_op("inc_wrap",  OP_INC, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0010, 1'b0);
        run_op("dec_wrap",  OP_DEC, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 4'b1001, 1'b0);

        // Abort a decimal ADC while it sits in the adjust cycle
        @(negedge clk);
        start = 1'b1; op = OP_ADC; a_in = 8'h99; b_in = 8'h01; c_in = 1'b0; d_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; d_in = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",   32'(busy),        32'h0);
        chk("abort_result", 32'(result_out),  32'h0);
        chk("abort_flags",  32'(flags_out),   32'h0);
        chk("abort_fv",     32'(flags_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_wr", 32'(wr_latch), 32'h0);
        end
        #1 rst_n = 1'b1;
        run_op("after_rst", OP_ADC, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1100, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op    = 4'($urandom);
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            c_in  = 1'($urandom);
            d_in  = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
